fetch_stall_ctrl: RTL and testbench

Fetch-side responder to the pipeline's hazard stall and branch redirect.
- Owns the PC register and the IF/ID pipeline register.
- Freezes fetch while the hazard detector asserts stall.
- Injects a bubble into ID/EX while fetch is frozen.
- Redirects the PC and flushes IF/ID on a taken branch.
- Guards against deadlocked interlocks with a consecutive-stall watchdog.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_stall_ctrl_stall_watchdog.sv | 44 ++++
 rtl/fetch_stall_ctrl.sv | 103 ++++++++++
 tb/tb_fetch_stall_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and FSM encoding.
// NOP_INSTR is all-zero so every register field reads as r0 to the hazard detector.
package fetch_pkg;

   localparam int unsigned PC_W      = 16;
   localparam int unsigned INSTR_W   = 16;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned MAX_STALL = 15;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      FSM_RUN      = 2'd0,
      FSM_STALL    = 2'd1,
      FSM_REDIRECT = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/fetch_stall_ctrl_stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag for interlock deadlock detection.
module stall_watchdog #(
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned MAX_STALL = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             eff_stall,
   input  logic             clear,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             stall_timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Clear has priority; otherwise count up and saturate at the trip point.
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (clear) begin
         cnt_d = '0;
      end else if (eff_stall) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         if (cnt_d == CNT_MAX) timeout_d = 1'b1;
      end
   end

   assign stall_cnt     = cnt_q;
   assign stall_timeout = timeout_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side PC / IF-ID owner: freezes on hazard stall, redirects and flushes on taken branch.
module fetch_stall_ctrl #(
   parameter int unsigned        PC_W      = fetch_pkg::PC_W,
   parameter int unsigned        INSTR_W   = fetch_pkg::INSTR_W,
   parameter int unsigned        PC_INC    = 1,
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
   parameter int unsigned        CNT_W     = fetch_pkg::CNT_W,
   parameter int unsigned        MAX_STALL = fetch_pkg::MAX_STALL
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               idex_bubble,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic               stall_timeout,
   output logic [1:0]         fsm_state
);

   import fetch_pkg::*;

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic               ifid_valid_q, ifid_valid_d;
   fsm_state_e         state_q, state_d;

   logic eff_stall_c;
   logic wd_clear_c;

   // A stall against a flushed/reset NOP in IF/ID is meaningless and must not freeze fetch.
   assign eff_stall_c = stall & ifid_valid_q;
   assign wd_clear_c  = branch_taken | ~eff_stall_c;
   assign idex_bubble = eff_stall_c | branch_taken | ~ifid_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         state_q      <= FSM_RUN;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         state_q      <= state_d;
      end
   end

   // Branch beats stall; stall holds everything; otherwise fetch advances.
   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      state_d      = state_q;
      if (branch_taken) begin
         pc_d         = branch_target;
         ifid_instr_d = NOP_INSTR;
         ifid_pc_d    = '0;
         ifid_valid_d = 1'b0;
         state_d      = FSM_REDIRECT;
      end else if (eff_stall_c) begin
         state_d = FSM_STALL;
      end else begin
         pc_d         = pc_q + PC_STEP;
         ifid_instr_d = imem_instr;
         ifid_pc_d    = pc_q + PC_STEP;
         ifid_valid_d = 1'b1;
         state_d      = FSM_RUN;
      end
   end

   stall_watchdog #(
      .CNT_W     (CNT_W),
      .MAX_STALL (MAX_STALL)
   ) u_watchdog (
      .clk           (clk),
      .rst           (rst),
      .eff_stall     (eff_stall_c),
      .clear         (wd_clear_c),
      .stall_cnt     (stall_cnt),
      .stall_timeout (stall_timeout)
   );

   assign pc         = pc_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Self-checking bench: directed plan cases plus randomized traffic against a behavioural model.
module tb_fetch_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] imem_instr;
   logic [15:0] pc;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic        ifid_valid;
   logic        idex_bubble;
   logic [3:0]  stall_cnt;
   logic        stall_timeout;
   logic [1:0]  fsm_state;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [15:0] m_pc, m_instr, m_ifpc;
   bit          m_valid, m_to;
   int          m_cnt, m_state;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      logic [15:0] r;
      r = a * 16'h1357;
      return r + 16'h1234;
   endfunction

   assign imem_instr = mem_fn(pc);

   fetch_stall_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_instr    (imem_instr),
      .pc            (pc),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_valid    (ifid_valid),
      .idex_bubble   (idex_bubble),
      .stall_cnt     (stall_cnt),
      .stall_timeout (stall_timeout),
      .fsm_state     (fsm_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000;
      m_valid = 0; m_to = 0; m_cnt = 0; m_state = 0;
   endtask

   // One rising edge of the specified fetch rules, using the inputs held across it.
   task automatic model_step();
      if (branch_taken) begin
         m_pc = branch_target; m_instr = 16'h0000; m_ifpc = 16'h0000;
         m_valid = 0; m_cnt = 0; m_state = 2;
      end else if (stall && m_valid) begin
         m_state = 2'd1;
         m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
         if (m_cnt == 15) m_to = 1;
      end else begin
         m_instr = mem_fn(m_pc);
         m_pc    = m_pc + 16'd1;
         m_ifpc  = m_pc;
         m_valid = 1; m_cnt = 0; m_state = 0;
      end
   endtask

   task automatic check_model();
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ifid_instr", 32'(ifid_instr), 32'(m_instr));
      chk("ifid_pc", 32'(ifid_pc), 32'(m_ifpc));
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("idex_bubble", 32'(idex_bubble),
          32'((stall & m_valid) | branch_taken | !m_valid));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
      chk("fsm_state", 32'(fsm_state), 32'(m_state));
   endtask

   // Drive at negedge (also releasing any reset), compare, then advance model across the edge.
   task automatic cycle(input bit s, input bit b, input logic [15:0] t);
      @(negedge clk);
      rst = 1'b1;
      stall = s; branch_taken = b; branch_target = t;
      #1 check_model();
      @(posedge clk);
      model_step();
      #2;
   endtask

   // Asynchronous reset asserted mid-cycle; released by the next cycle() call.
   task automatic mid_reset();
      rst = 1'b0;
      #1 model_reset();
      check_model();
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      model_reset();
      #3 check_model();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_bubble", 32'(idex_bubble), 32'h1);
      chk("rst_valid", 32'(ifid_valid), 32'h0);

      // Reset release and first fetch
      cycle(0, 0, 16'h0);
      chk("t1_pc", 32'(pc), 32'h1);
      chk("t1_instr", 32'(ifid_instr), 32'h1234);
      chk("t1_ifpc", 32'(ifid_pc), 32'h1);
      chk("t1_valid", 32'(ifid_valid), 32'h1);
      chk("t1_bubble", 32'(idex_bubble), 32'h0);

      // Three stalls then release
      for (int k = 1; k <= 3; k++) begin
         cycle(1, 0, 16'h0);
         chk("t2_cnt", 32'(stall_cnt), 32'(k));
         chk("t2_pc", 32'(pc), 32'h1);
         chk("t2_state", 32'(fsm_state), 32'h1);
         chk("t2_bubble", 32'(idex_bubble), 32'h1);
      end
      cycle(0, 0, 16'h0);
      chk("t2_pc_adv", 32'(pc), 32'h2);
      chk("t2_cnt_clr", 32'(stall_cnt), 32'h0);
      chk("t2_run", 32'(fsm_state), 32'h0);

      // Branch with simultaneous stall, then stall during REDIRECT is ignored
      cycle(1, 1, 16'h0040);
      chk("t3_pc", 32'(pc), 32'h40);
      chk("t3_valid", 32'(ifid_valid), 32'h0);
      chk("t3_instr", 32'(ifid_instr), 32'h0);
      chk("t3_state", 32'(fsm_state), 32'h2);
      cycle(1, 0, 16'h0);
      chk("t3_instr40", 32'(ifid_instr), 32'hE7F4);
      chk("t3_pc41", 32'(pc), 32'h41);
      chk("t3_cnt", 32'(stall_cnt), 32'h0);

      // Watchdog trip, saturation and stickiness
      for (int k = 1; k <= 16; k++) begin
         cycle(1, 0, 16'h0);
         chk("t4_cnt", 32'(stall_cnt), 32'((k > 15) ? 15 : k));
         chk("t4_to", 32'(stall_timeout), 32'((k >= 15) ? 1 : 0));
      end
      cycle(0, 0, 16'h0);
      chk("t4_sticky", 32'(stall_timeout), 32'h1);
      chk("t4_cnt_clr", 32'(stall_cnt), 32'h0);

      // PC wrap
      cycle(0, 1, 16'hFFFF);
      cycle(0, 0, 16'h0);
      chk("t5_pc", 32'(pc), 32'h0);
      chk("t5_ifpc", 32'(ifid_pc), 32'h0);

      // Mid-cycle reset during stall, then stall ignored with IF/ID empty
      cycle(1, 0, 16'h0);
      cycle(1, 0, 16'h0);
      mid_reset();
      chk("t6_to", 32'(stall_timeout), 32'h0);
      chk("t6_pc", 32'(pc), 32'h0);
      chk("t6_bubble", 32'(idex_bubble), 32'h1);
      cycle(1, 0, 16'h0);
      chk("t6_pc_adv", 32'(pc), 32'h1);
      chk("t6_cnt", 32'(stall_cnt), 32'h0);

      // Randomized traffic with phases of heavy stalling
      for (int i = 0; i < 3000; i++) begin
         bit s, b;
         logic [15:0] t;
         int sp;
         sp = ((i / 200) % 3 == 1) ? 95 : 35;
         s  = ($urandom_range(0, 99) < sp);
         b  = ($urandom_range(0, 99) < 8);
         t  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7)))
                                          : 16'($urandom);
         cycle(s, b, t);
         if ($urandom_range(0, 299) == 0) mid_reset();
      end
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
      #1 check_model();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
